// File: rtl/input_port_ctrl.sv
// Input-port controller: pops the buffer head, XY-routes HEAD flits and forwards granted flits to the crossbar.
// Latency: HEAD seen in IDLE -> request next cycle; grant in cycle N -> pop in N, registered flit out in N+1.
// Backpressure: no pop and no output unless the request is granted; orphan BODY/TAIL flits are dropped with err_o.
module input_port_ctrl #(
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int FLIT_W = 16,
    parameter logic [X_W-1:0] X_CURRENT = '0,
    parameter logic [Y_W-1:0] Y_CURRENT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buf_empty_i,
    input  logic [FLIT_W-1:0] buf_data_i,
    output logic              buf_read_o,
    output logic              sa_req_o,
    output logic [2:0]        sa_port_o,
    input  logic              sa_grant_i,
    output logic [FLIT_W-1:0] xb_flit_o,
    output logic              xb_valid_o,
    output logic              err_o
);

    // Flit layout, MSB first: label[1:0], x_dest, y_dest, payload.
    localparam logic [1:0] LBL_HEAD     = 2'b00;
    localparam logic [1:0] LBL_BODY     = 2'b01;
    localparam logic [1:0] LBL_TAIL     = 2'b10;
    localparam logic [1:0] LBL_HEADTAIL = 2'b11;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         state_q;
    logic [2:0]     route_q;
    logic [2:0]     route_c;
    logic [1:0]     label;
    logic [X_W-1:0] x_dest;
    logic [Y_W-1:0] y_dest;
    logic           is_head;
    logic           is_tail;
    logic           drop;
    logic           fwd;

    assign label   = buf_data_i[FLIT_W-1 -: 2];
    assign x_dest  = buf_data_i[FLIT_W-3 -: X_W];
    assign y_dest  = buf_data_i[FLIT_W-3-X_W -: Y_W];
    assign is_head = (label == LBL_HEAD) || (label == LBL_HEADTAIL);
    assign is_tail = (label == LBL_TAIL) || (label == LBL_HEADTAIL);

    // Dimension-order routing: resolve X before Y.
    always_comb begin
        route_c = PORT_LOCAL;
        if (x_dest > X_CURRENT)
            route_c = PORT_EAST;
        else if (x_dest < X_CURRENT)
            route_c = PORT_WEST;
        else if (y_dest > Y_CURRENT)
            route_c = PORT_NORTH;
        else if (y_dest < Y_CURRENT)
            route_c = PORT_SOUTH;
    end

    // rst_n gate keeps an orphan at the buffer head from popping while reset is held.
    assign drop       = rst_n && (state_q == IDLE) && !buf_empty_i && !is_head;
    assign sa_req_o   = (state_q == ACTIVE) && !buf_empty_i;
    assign sa_port_o  = sa_req_o ? route_q : PORT_LOCAL;
    assign fwd        = sa_req_o && sa_grant_i;
    assign buf_read_o = drop || fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            route_q    <= PORT_LOCAL;
            xb_flit_o  <= '0;
            xb_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o      <= drop;
            xb_valid_o <= fwd;
            if (fwd)
                xb_flit_o <= buf_data_i;
            case (state_q)
                IDLE: begin
                    if (!buf_empty_i && is_head) begin
                        route_q <= route_c;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fwd && is_tail)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl with X_CURRENT=1, Y_CURRENT=1 and a small buffer model.
module tb_input_port_ctrl;

    localparam logic [1:0] HEAD     = 2'b00;
    localparam logic [1:0] BODY     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        buf_empty_i;
    logic [15:0] buf_data_i;
    logic        buf_read_o;
    logic        sa_req_o;
    logic [2:0]  sa_port_o;
    logic        sa_grant_i = 1'b0;
    logic [15:0] xb_flit_o;
    logic        xb_valid_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    logic viol = 1'b0;

    logic [15:0] mem [0:15];
    int rd_ptr = 0;
    int wr_ptr = 0;

    input_port_ctrl #(
        .X_W(4), .Y_W(4), .FLIT_W(16),
        .X_CURRENT(4'd1), .Y_CURRENT(4'd1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buf_empty_i(buf_empty_i),
        .buf_data_i (buf_data_i),
        .buf_read_o (buf_read_o),
        .sa_req_o   (sa_req_o),
        .sa_port_o  (sa_port_o),
        .sa_grant_i (sa_grant_i),
        .xb_flit_o  (xb_flit_o),
        .xb_valid_o (xb_valid_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Buffer model: head pops on the rising edge where buf_read_o is high.
    assign buf_empty_i = (rd_ptr == wr_ptr);
    assign buf_data_i  = mem[rd_ptr[3:0]];
    always @(posedge clk) begin
        if (buf_read_o && buf_empty_i)
            viol <= 1'b1;
        if (buf_read_o && !buf_empty_i)
            rd_ptr <= rd_ptr + 1;
    end

    function automatic logic [15:0] mk(input logic [1:0] lbl, input logic [3:0] x,
                                       input logic [3:0] y, input logic [5:0] pl);
        return {lbl, x, y, pl};
    endfunction

    task automatic push(input logic [15:0] f);
        mem[wr_ptr[3:0]] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] port;
    } route_vec_t;

    route_vec_t rv [6];
    logic [15:0] pkt [4];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rv[0] = '{x: 4'd0,  y: 4'd1,  port: 3'd4};
        rv[1] = '{x: 4'd1,  y: 4'd2,  port: 3'd1};
        rv[2] = '{x: 4'd1,  y: 4'd0,  port: 3'd2};
        rv[3] = '{x: 4'd1,  y: 4'd1,  port: 3'd0};
        rv[4] = '{x: 4'd15, y: 4'd0,  port: 3'd3};
        rv[5] = '{x: 4'd0,  y: 4'd15, port: 3'd4};

        // Reset values
        #1;
        chk("rst_sa_req", sa_req_o, 1'b0);
        chk("rst_sa_port", sa_port_o, 3'd0);
        chk("rst_buf_read", buf_read_o, 1'b0);
        chk("rst_xb_valid", xb_valid_o, 1'b0);
        chk("rst_xb_flit", xb_flit_o, 16'h0);
        chk("rst_err", err_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-flit packet to EAST with grant tied high
        @(negedge clk);
        push(mk(HEAD, 4'd3, 4'd1, 6'd1));
        push(mk(TAIL, 4'd3, 4'd1, 6'd2));
        sa_grant_i = 1'b1;
        #1;
        chk("t1_c0_req", sa_req_o, 1'b0);
        chk("t1_c0_rd", buf_read_o, 1'b0);
        @(negedge clk); #1;
        chk("t1_c1_req", sa_req_o, 1'b1);
        chk("t1_c1_port", sa_port_o, 3'd3);
        chk("t1_c1_rd", buf_read_o, 1'b1);
        chk("t1_c1_nograntout", xb_valid_o, 1'b0);
        @(negedge clk); #1;
        chk("t1_c2_vld", xb_valid_o, 1'b1);
        chk("t1_c2_flit", xb_flit_o, mk(HEAD, 4'd3, 4'd1, 6'd1));
        chk("t1_c2_port", sa_port_o, 3'd3);
        @(negedge clk); #1;
        chk("t1_c3_vld", xb_valid_o, 1'b1);
        chk("t1_c3_flit", xb_flit_o, mk(TAIL, 4'd3, 4'd1, 6'd2));
        chk("t1_c3_req", sa_req_o, 1'b0);
        @(negedge clk); #1;
        chk("t1_c4_vld", xb_valid_o, 1'b0);

        // Route sweep with single-flit packets
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push(mk(HEADTAIL, rv[i].x, rv[i].y, 6'(i)));
            #1;
            chk("sweep_idle_req", sa_req_o, 1'b0);
            @(negedge clk); #1;
            chk("sweep_req", sa_req_o, 1'b1);
            chk("sweep_port", sa_port_o, rv[i].port);
            @(negedge clk); #1;
            chk("sweep_vld", xb_valid_o, 1'b1);
            chk("sweep_flit", xb_flit_o, mk(HEADTAIL, rv[i].x, rv[i].y, 6'(i)));
            chk("sweep_back_idle", sa_req_o, 1'b0);
        end

        // Four-flit packet to NORTH, grant held low for three cycles
        pkt[0] = mk(HEAD, 4'd1, 4'd2, 6'd10);
        pkt[1] = mk(BODY, 4'd0, 4'd0, 6'd11);
        pkt[2] = mk(BODY, 4'd0, 4'd0, 6'd12);
        pkt[3] = mk(TAIL, 4'd0, 4'd0, 6'd13);
        @(negedge clk);
        sa_grant_i = 1'b0;
        for (int k = 0; k < 4; k++) push(pkt[k]);
        #1;
        chk("t3_c0_req", sa_req_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("t3_wait_req", sa_req_o, 1'b1);
            chk("t3_wait_port", sa_port_o, 3'd1);
            chk("t3_wait_rd", buf_read_o, 1'b0);
            chk("t3_wait_vld", xb_valid_o, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sa_grant_i = 1'b1;
            #1;
            chk("t3_rd", buf_read_o, 1'b1);
            chk("t3_port", sa_port_o, 3'd1);
            chk("t3_vld", xb_valid_o, k > 0);
            if (k > 0) chk("t3_flit", xb_flit_o, pkt[k-1]);
        end
        @(negedge clk); #1;
        chk("t3_last_vld", xb_valid_o, 1'b1);
        chk("t3_last_flit", xb_flit_o, pkt[3]);
        chk("t3_last_req", sa_req_o, 1'b0);

        // Buffer runs dry mid-packet (WEST), then refilled with the TAIL
        @(negedge clk);
        push(mk(HEAD, 4'd0, 4'd1, 6'd20));
        push(mk(BODY, 4'd0, 4'd0, 6'd21));
        #1;
        chk("t4_c0_req", sa_req_o, 1'b0);
        @(negedge clk); #1;
        chk("t4_c1_port", sa_port_o, 3'd4);
        @(negedge clk); #1;
        chk("t4_c2_rd", buf_read_o, 1'b1);
        @(negedge clk); #1;
        chk("t4_empty_req", sa_req_o, 1'b0);
        chk("t4_empty_port", sa_port_o, 3'd0);
        chk("t4_empty_rd", buf_read_o, 1'b0);
        chk("t4_body_out", xb_flit_o, mk(BODY, 4'd0, 4'd0, 6'd21));
        @(negedge clk); #1;
        chk("t4_idle_grant_vld", xb_valid_o, 1'b0);
        @(negedge clk);
        push(mk(TAIL, 4'd0, 4'd0, 6'd22));
        #1;
        chk("t4_resume_req", sa_req_o, 1'b1);
        chk("t4_resume_port", sa_port_o, 3'd4);
        @(negedge clk); #1;
        chk("t4_tail_flit", xb_flit_o, mk(TAIL, 4'd0, 4'd0, 6'd22));
        chk("t4_tail_vld", xb_valid_o, 1'b1);
        @(negedge clk);
        push(mk(HEADTAIL, 4'd1, 4'd1, 6'd23));
        #1;
        chk("t4_idle_again", sa_req_o, 1'b0);
        @(negedge clk); #1;
        chk("t4_new_port", sa_port_o, 3'd0);
        chk("t4_new_req", sa_req_o, 1'b1);
        @(negedge clk);

        // Orphan BODY at the head while idle
        @(negedge clk);
        push(mk(BODY, 4'd2, 4'd2, 6'd30));
        #1;
        chk("t5_drop_rd", buf_read_o, 1'b1);
        chk("t5_drop_req", sa_req_o, 1'b0);
        chk("t5_err_early", err_o, 1'b0);
        @(negedge clk); #1;
        chk("t5_err", err_o, 1'b1);
        chk("t5_rd_after", buf_read_o, 1'b0);
        chk("t5_req_after", sa_req_o, 1'b0);
        @(negedge clk); #1;
        chk("t5_err_clear", err_o, 1'b0);

        // Reset mid-packet after two flits forwarded
        @(negedge clk);
        push(mk(HEAD, 4'd3, 4'd1, 6'd40));
        push(mk(BODY, 4'd0, 4'd0, 6'd41));
        push(mk(BODY, 4'd0, 4'd0, 6'd42));
        push(mk(TAIL, 4'd0, 4'd0, 6'd43));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t6_pre_vld", xb_valid_o, 1'b1);
        chk("t6_pre_req", sa_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", xb_valid_o, 1'b0);
        chk("t6_rst_flit", xb_flit_o, 16'h0);
        chk("t6_rst_req", sa_req_o, 1'b0);
        chk("t6_rst_port", sa_port_o, 3'd0);
        chk("t6_rst_rd", buf_read_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_orphan1_rd", buf_read_o, 1'b1);
        chk("t6_orphan1_err", err_o, 1'b0);
        @(negedge clk); #1;
        chk("t6_orphan2_rd", buf_read_o, 1'b1);
        chk("t6_orphan2_err", err_o, 1'b1);
        chk("t6_orphan2_req", sa_req_o, 1'b0);
        @(negedge clk); #1;
        chk("t6_err_tail", err_o, 1'b1);
        chk("t6_empty_rd", buf_read_o, 1'b0);
        @(negedge clk); #1;
        chk("t6_err_clear", err_o, 1'b0);

        chk("no_pop_when_empty", viol, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_port_ctrl.md
# input_port_ctrl

Downstream consumer of the router input circular buffer. It pops flits from the buffer head, computes the XY output port from each HEAD flit and holds that route until the packet's TAIL. It requests the switch allocator and forwards granted flits one per cycle into a registered crossbar-side output. One instance sits per router input port, between the input buffer and the switch allocator / crossbar.

## Interface
- X_CURRENT, default 0: X coordinate of this router, width x_Des.
- Y_CURRENT, default 0: Y coordinate of this router, width y_Des.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- buf_empty_i  in  1  buffer buf_empty.
- buf_data_i  in  flit_Data_noVC  buffer output_Data; oldest flit, valid while buf_empty_i=0.
- buf_read_o  out  1  drives buffer read_i; the head flit pops on the rising edge where this is 1.
- sa_req_o  out  1  switch-allocator request.
- sa_port_o  out  3  requested output port: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- sa_grant_i  in  1  grant for this input port. Only meaningful while sa_req_o=1.
- xb_flit_o  out  flit_Data_noVC  flit to the crossbar (registered).
- xb_valid_o  out  1  xb_flit_o valid (registered).
- err_o  out  1  one-cycle pulse when an orphan BODY or TAIL flit is dropped.

## Operation
- Reset values: state IDLE, route_q=LOCAL, sa_req_o=0, sa_port_o=0, buf_read_o=0, xb_valid_o=0, xb_flit_o=0, err_o=0.
- XY route from the HEAD flit header, using unsigned compares:
  - x_Dest > X_CURRENT gives EAST; x_Dest < X_CURRENT gives WEST.
  - Otherwise, y_Dest > Y_CURRENT gives NORTH; y_Dest < Y_CURRENT gives SOUTH.
  - Otherwise, LOCAL.
- State IDLE:
  - sa_req_o=0.
  - If buf_empty_i=0 and the label is HEAD or HEADTAIL: latch the computed route into route_q and go to ACTIVE. No pop occurs in this cycle.
  - If buf_empty_i=0 and the label is BODY or TAIL: buf_read_o=1 (drop the flit), err_o=1 in the next cycle, stay in IDLE.
- State ACTIVE:
  - sa_req_o = !buf_empty_i; sa_port_o = route_q.
  - Forward condition is sa_req_o & sa_grant_i. When it holds: buf_read_o=1 combinationally, and buf_data_i is registered into xb_flit_o with xb_valid_o=1 on the next edge.
  - If the forwarded label is TAIL or HEADTAIL, go to IDLE at that edge. Otherwise stay in ACTIVE.
  - If the forward condition does not hold: no pop, and xb_valid_o=0 next cycle.
- A HEAD flit seen while in ACTIVE is forwarded as an ordinary flit; the route is not recomputed.
- sa_port_o reads 0 whenever sa_req_o=0.

## Timing
- Head-to-request latency: a HEAD visible at cycle 0 in IDLE gives sa_req_o=1 with a valid sa_port_o at cycle 1.
- Grant-to-output latency: a grant in cycle N gives buf_read_o=1 in cycle N and xb_valid_o=1 with the flit in cycle N+1.
- Throughput: one flit per cycle under a continuous grant with a non-empty buffer.
- A single-flit HEADTAIL packet occupies 2 cycles (IDLE, then ACTIVE). The next head is evaluated in the cycle after the return to IDLE.
- Buffer empty mid-packet: sa_req_o drops the same cycle, and the state stays ACTIVE with route_q held. The request re-asserts the cycle the buffer becomes non-empty.
- A grant while sa_req_o=0 is ignored: no pop and no output.
- buf_read_o is never 1 while buf_empty_i=1.
- Reset asserted mid-packet: all outputs and state immediately return to their reset values, asynchronously. The remaining flits of that packet are then dropped as orphans, with err_o pulsing once per flit.
- Release of rst_n: the first state change occurs at the first rising edge after release.

## Test plan
- X_CURRENT=1, Y_CURRENT=1; HEAD x_Dest=3, y_Dest=1; grant tied high -> sa_req_o=1 with sa_port_o=3 (EAST) at cycle 1, xb_valid_o=1 at cycle 2, state back to IDLE after the TAIL.
- Route sweep with destinations (0,1), (1,2), (1,0), (1,1) -> sa_port_o = 4, 1, 2, 0 respectively.
- 4-flit packet (HEAD, BODY, BODY, TAIL) with grant low for 3 cycles then high -> no pops while grant is low, then 4 consecutive xb_valid_o cycles in order, sa_port_o constant throughout.
- Buffer empties after the BODY flit -> sa_req_o=0 and route held; refill with TAIL -> request resumes with the same port, TAIL forwarded, return to IDLE.
- Buffer head is a BODY flit while in IDLE -> buf_read_o=1 for one cycle, err_o pulses once, no request issued.
- rst_n pulled low while in ACTIVE after 2 flits forwarded -> outputs at reset values immediately; after release, the remaining BODY and TAIL flits each raise err_o.
